// File: rtl/btn_gesture_decoder_if.sv
// Signal bundle between a button gesture decoder and its consumer.
// master drives the button level and enable; slave (the decoder) drives the gesture pulses.
`timescale 1ns/1ps
interface btn_gesture_decoder_if;
    logic       btn_level;
    logic       en;
    logic       short_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       double_pulse;
    logic       busy;
    logic [2:0] state_dbg;

    modport master (
        output btn_level, en,
        input  short_pulse, long_pulse, repeat_pulse, double_pulse, busy, state_dbg
    );

    modport slave (
        input  btn_level, en,
        output short_pulse, long_pulse, repeat_pulse, double_pulse, busy, state_dbg
    );
endinterface

// File: rtl/btn_gesture_decoder.sv
// Classifies debounced button activity into short press, long press with auto-repeat,
// and double click; each recognised gesture yields one registered single-cycle pulse.
`timescale 1ns/1ps
module btn_gesture_decoder #(
    parameter int                 CNT_W       = 26,
    parameter logic [CNT_W-1:0]   LONG_TIME   = 26'd50_000_000,
    parameter logic [CNT_W-1:0]   DOUBLE_GAP  = 26'd12_500_000,
    parameter logic [CNT_W-1:0]   REPEAT_TIME = 26'd5_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    btn_gesture_decoder_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HOLD = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_LAST = LONG_TIME - ONE;
    localparam logic [CNT_W-1:0] GAP_LAST  = DOUBLE_GAP - ONE;
    localparam logic [CNT_W-1:0] REP_LAST  = REPEAT_TIME - ONE;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             double_q, double_d;
    logic             busy_q, busy_d;
    logic             rise;

    assign rise = bus.btn_level & ~level_q;

    // level_q resets high so a button already held at reset release never counts as a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            level_q  <= 1'b1;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            double_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= bus.btn_level;
            short_q  <= short_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            double_q <= double_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        double_d = 1'b0;

        if (!bus.en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (rise) state_d = PRESS1;
                end
                // release is tested first so it beats the long threshold on the same cycle
                PRESS1: begin
                    if (!bus.btn_level) begin
                        state_d = WAIT2;
                        cnt_d   = '0;
                    end else if (cnt_q == LONG_LAST) begin
                        long_d  = 1'b1;
                        state_d = LONG_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                // a press on the gap-expiry cycle still counts as the second click
                WAIT2: begin
                    if (bus.btn_level) begin
                        state_d = PRESS2;
                        cnt_d   = '0;
                    end else if (cnt_q == GAP_LAST) begin
                        short_d = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                PRESS2: begin
                    cnt_d = '0;
                    if (!bus.btn_level) begin
                        double_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
                LONG_HOLD: begin
                    if (!bus.btn_level) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == REP_LAST) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign bus.short_pulse  = short_q;
    assign bus.long_pulse   = long_q;
    assign bus.repeat_pulse = repeat_q;
    assign bus.double_pulse = double_q;
    assign bus.busy         = busy_q;
    assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_btn_gesture_decoder.sv
// Directed bench for btn_gesture_decoder with LONG_TIME=10, DOUBLE_GAP=6, REPEAT_TIME=4.
`timescale 1ns/1ps
module tb_btn_gesture_decoder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    btn_gesture_decoder_if bus ();

    btn_gesture_decoder #(
        .CNT_W       (26),
        .LONG_TIME   (26'd10),
        .DOUBLE_GAP  (26'd6),
        .REPEAT_TIME (26'd4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // pulse field order: {short, long, repeat, double}
    localparam logic [3:0] P0 = 4'b0000;
    localparam logic [3:0] PS = 4'b1000;
    localparam logic [3:0] PL = 4'b0100;
    localparam logic [3:0] PR = 4'b0010;
    localparam logic [3:0] PD = 4'b0001;

    typedef struct {
        logic       btn;
        logic       en;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [7:0] expect_of(input logic [3:0] p, input logic [2:0] st);
        return {p, (st != 3'd0), st};
    endfunction

    function automatic void add(input logic b, input logic e, input logic [3:0] p, input logic [2:0] st);
        vec_t v;
        v.btn = b;
        v.en  = e;
        v.exp = expect_of(p, st);
        vecs.push_back(v);
    endfunction

    function automatic void addn(input logic b, input logic e, input logic [2:0] st, input int n);
        for (int i = 0; i < n; i++) add(b, e, P0, st);
    endfunction

    function automatic logic [7:0] outs();
        return {bus.short_pulse, bus.long_pulse, bus.repeat_pulse, bus.double_pulse,
                bus.busy, bus.state_dbg};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {s,l,r,d,busy,st}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic b, input logic e);
        bus.btn_level = b;
        bus.en        = e;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_step(input string name, input logic b, input logic e,
                            input logic [3:0] p, input logic [2:0] st);
        step(b, e);
        check(name, outs(), expect_of(p, st));
    endtask

    initial begin
        // short press: 3 high, release -> WAIT2 for 6 edges, short on the 6th after release
        add(0, 1, P0, 0);
        addn(1, 1, 1, 3);
        addn(0, 1, 2, 6);
        add(0, 1, PS, 0);
        addn(0, 1, 0, 3);

        // long hold, 25 high: long at edge 10, repeats at 14/18/22, silent release
        add(1, 1, P0, 1);
        addn(1, 1, 1, 9);
        add(1, 1, PL, 4);
        for (int k = 0; k < 3; k++) begin
            addn(1, 1, 4, 3);
            add(1, 1, PR, 4);
        end
        addn(1, 1, 4, 2);
        add(0, 1, P0, 0);
        addn(0, 1, 0, 8);

        // double click: high 2, low 3, high 2, low
        addn(1, 1, 1, 2);
        addn(0, 1, 2, 3);
        addn(1, 1, 3, 2);
        add(0, 1, PD, 0);
        addn(0, 1, 0, 8);

        // gap just long enough for short, then a fresh press gives a second short
        addn(1, 1, 1, 2);
        addn(0, 1, 2, 6);
        add(0, 1, PS, 0);
        addn(1, 1, 1, 2);
        addn(0, 1, 2, 6);
        add(0, 1, PS, 0);
        add(0, 1, P0, 0);

        // press on the gap-expiry cycle wins -> double, no short
        addn(1, 1, 1, 2);
        addn(0, 1, 2, 6);
        add(1, 1, P0, 3);
        add(1, 1, P0, 3);
        add(0, 1, PD, 0);
        addn(0, 1, 0, 2);

        // shorter gap of 5 -> double
        addn(1, 1, 1, 2);
        addn(0, 1, 2, 5);
        addn(1, 1, 3, 2);
        add(0, 1, PD, 0);
        addn(0, 1, 0, 2);

        // en drop at PRESS1 cnt=5; re-enable while held must not start a press
        add(1, 1, P0, 1);
        addn(1, 1, 1, 5);
        add(1, 0, P0, 0);
        addn(1, 0, 0, 4);
        addn(1, 1, 0, 8);
        addn(0, 1, 0, 8);

        rst_n         = 1'b0;
        bus.btn_level = 1'b0;
        bus.en        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", outs(), 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].btn, vecs[i].en);
            checks++;
            if (outs() !== vecs[i].exp) begin
                errors++;
                $display("FAIL vec[%0d]: got {s,l,r,d,busy,st}=%b expected %b", i, outs(), vecs[i].exp);
            end
        end

        // button held through reset release stays ignored until seen low
        rst_n = 1'b0;
        step(1, 1);
        step(1, 1);
        check("held_in_reset", outs(), 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) chk_step("held_after_reset", 1, 1, P0, 0);
        chk_step("held_release", 0, 1, P0, 0);
        chk_step("held_press1", 1, 1, P0, 1);
        chk_step("held_press1b", 1, 1, P0, 1);
        for (int i = 0; i < 6; i++) chk_step("held_wait2", 0, 1, P0, 2);
        chk_step("held_short", 0, 1, PS, 0);

        // async reset during LONG_HOLD clears outputs before the next edge
        chk_step("lh_entry", 1, 1, P0, 1);
        for (int i = 0; i < 9; i++) chk_step("lh_press1", 1, 1, P0, 1);
        chk_step("lh_long", 1, 1, PL, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", outs(), 8'h00);
        step(1, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) chk_step("post_rst_held", 1, 1, P0, 0);
        chk_step("post_rst_low", 0, 1, P0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
